// File: rtl/riscv_lsu_ctrl.sv
// rtl/riscv_lsu_ctrl.sv - load/store controller between core datapath and data memory
// Issues one registered bus request per legal access, stalls the core, extends load data.
module riscv_lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        core_bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [CNT_WIDTH-1:0] LP_TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [3:0]           r_mem_be;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wd;
    logic [2:0]           r_size;
    logic [1:0]           r_lane;
    logic [31:0]          r_rd;
    logic                 r_err;

    logic                 w_illegal;
    logic [3:0]           w_be;
    logic [31:0]          w_wd;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ext;
    logic                 w_tmo;
    logic                 w_stall;
    logic                 w_misalign;
    logic                 w_bus_err;

    always_comb begin
        w_illegal = 1'b0;
        w_be      = 4'b0000;
        w_wd      = core_wd_i;
        case (core_size_i)
            3'd0, 3'd4: begin
                w_be = 4'b0001 << core_addr_i[1:0];
                w_wd = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                w_illegal = core_addr_i[0];
                w_be      = core_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wd      = {2{core_wd_i[15:0]}};
            end
            3'd2: begin
                w_illegal = (core_addr_i[1:0] != 2'b00);
                w_be      = 4'b1111;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Lane selection uses the address captured at issue, not the live ALU output.
    assign w_byte = mem_rd_i[8*r_lane +: 8];
    assign w_half = r_lane[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        w_ext = mem_rd_i;
        case (r_size)
            3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_ext = {24'h0, w_byte};
            3'd1:    w_ext = {{16{w_half[15]}}, w_half};
            3'd5:    w_ext = {16'h0, w_half};
            default: w_ext = mem_rd_i;
        endcase
    end

    assign w_tmo = (r_cnt == LP_TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_misalign = 1'b0;
        w_bus_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (core_req_i) begin
                    if (w_illegal) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        w_next  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (mem_ready_i || w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_bus_err = r_err;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Core-facing strobes stay quiet while reset is held.
        if (rst_i) begin
            w_stall    = 1'b0;
            w_misalign = 1'b0;
            w_bus_err  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= 4'b0000;
            r_mem_addr <= 32'h0;
            r_mem_wd   <= 32'h0;
            r_size     <= 3'd0;
            r_lane     <= 2'b00;
            r_rd       <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core_req_i && !w_illegal) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= core_we_i;
                        r_mem_be   <= w_be;
                        r_mem_addr <= {core_addr_i[31:2], 2'b00};
                        r_mem_wd   <= w_wd;
                        r_size     <= core_size_i;
                        r_lane     <= core_addr_i[1:0];
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        if (!r_mem_we) begin
                            r_rd <= w_ext;
                        end
                    end else if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_rd      <= 32'h0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_rd_o       = r_rd;
    assign core_stall_o    = w_stall;
    assign core_misalign_o = w_misalign;
    assign core_bus_err_o  = w_bus_err;
    assign mem_req_o       = r_mem_req;
    assign mem_we_o        = r_mem_we;
    assign mem_be_o        = r_mem_be;
    assign mem_addr_o      = r_mem_addr;
    assign mem_wd_o        = r_mem_wd;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb/tb_riscv_lsu_ctrl.sv - directed vectors for riscv_lsu_ctrl
module tb_riscv_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        core_bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    riscv_lsu_ctrl #(
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH(5)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .core_req_i(core_req_i),
        .core_we_i(core_we_i),
        .core_size_i(core_size_i),
        .core_addr_i(core_addr_i),
        .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o),
        .core_misalign_o(core_misalign_o),
        .core_bus_err_o(core_bus_err_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o),
        .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ready_at = REQ cycle (1-based) in which memory answers; 0 = never answers.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int ready_at,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        int n_req;
        int n_stall;
        bit done;
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        #1;
        check("idle_stall", core_stall_o, 1);
        check("idle_misalign", core_misalign_o, 0);
        n_stall = core_stall_o ? 1 : 0;
        n_req   = 0;
        done    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk_i); #1;
            if (mem_req_o) begin
                n_req++;
                if (core_stall_o) n_stall++;
                if (n_req == 1) begin
                    check("mem_be", mem_be_o, exp_be);
                    check("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
                    check("mem_wd", mem_wd_o, exp_wd);
                    check("mem_we", mem_we_o, we);
                end
                core_req_i = 1'b0;
                if (n_req == ready_at) begin
                    mem_ready_i = 1'b1;
                    mem_rd_i    = rdata;
                end else begin
                    mem_ready_i = 1'b0;
                    mem_rd_i    = 32'hDEAD_BEEF;
                end
            end else begin
                done = 1'b1;
            end
        end
        mem_ready_i = 1'b0;
        check("resp_reached", done, 1);
        check("req_cycles", n_req, (ready_at == 0) ? 16 : ready_at);
        check("stall_cycles", n_stall, n_req + 1);
        check("resp_stall", core_stall_o, 0);
        check("resp_bus_err", core_bus_err_o, (ready_at == 0) ? 1 : 0);
        if (!we) check("resp_rd", core_rd_o, exp_rd);
    endtask

    task automatic misalign(input logic [2:0] size, input logic [31:0] addr);
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = size;
        core_addr_i = addr;
        #1;
        check("mis_pulse", core_misalign_o, 1);
        check("mis_stall", core_stall_o, 0);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        #1;
        check("mis_no_req", mem_req_o, 0);
        check("mis_clear", core_misalign_o, 0);
    endtask

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_stall", core_stall_o, 0);
        core_req_i = 1'b0;
        rst_i      = 1'b0;
        @(posedge clk_i); #1;
        check("post_rst_req", mem_req_o, 0);
        check("post_rst_we", mem_we_o, 0);
        check("post_rst_be", mem_be_o, 0);
        check("post_rst_addr", mem_addr_o, 0);
        check("post_rst_wd", mem_wd_o, 0);
        check("post_rst_rd", core_rd_o, 0);
        check("post_rst_stall", core_stall_o, 0);
        check("post_rst_err", core_bus_err_o, 0);

        access(1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 1, 4'b1000, 32'hDDDD_DDDD, 32'h0);
        access(1'b0, 3'd0, 32'h0000_2001, 32'h0, 32'h1234_F6FF, 3, 4'b0010, 32'h0, 32'hFFFF_FFF6);
        access(1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h1234_F6FF, 3, 4'b0010, 32'h0, 32'h0000_00F6);

        misalign(3'd2, 32'h0000_3002);
        misalign(3'd1, 32'h0000_3001);
        misalign(3'd3, 32'h0000_3000);

        access(1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        check("tmo_err_clear", core_bus_err_o, 0);

        access(1'b0, 3'd1, 32'h0000_4002, 32'h0, 32'h8001_0000, 1, 4'b1100, 32'h0, 32'hFFFF_8001);
        access(1'b1, 3'd2, 32'h0000_4004, 32'h1357_9BDF, 32'h0, 1, 4'b1111, 32'h1357_9BDF, 32'h0);
        access(1'b0, 3'd5, 32'h0000_4002, 32'h0, 32'h8001_7777, 2, 4'b1100, 32'h0, 32'h0000_8001);
        access(1'b1, 3'd1, 32'h0000_4006, 32'h0000_BEEF, 32'h0, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        @(posedge clk_i); #1;
        check("no_dup_req", mem_req_o, 0);
        check("final_stall", core_stall_o, 0);

        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0000_6000;
        @(posedge clk_i); #1;
        check("midrst_req_up", mem_req_o, 1);
        core_req_i  = 1'b0;
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        #1;
        check("midrst_stall", core_stall_o, 0);
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        mem_ready_i = 1'b0;
        check("midrst_req_down", mem_req_o, 0);
        @(posedge clk_i); #1;
        check("midrst_idle", mem_req_o, 0);
        check("midrst_err", core_bus_err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
- Load/store controller between the core datapath and the data memory.
- Takes `mem_req`/`mem_we`/`mem_size` from the main decoder together with the ALU-computed address and rs2 data.
- Drives a ready-handshake data-memory bus with byte enables, and stalls the core until the access completes.
- Sign/zero-extends load data, flags misaligned or unsupported accesses, and times out unresponsive memory.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ waiting for `mem_ready_i` before bus error; must be >= 1.
- CNT_WIDTH, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- core_req_i  input  1  load/store requested by the current instruction (decoder `mem_req_o`).
- core_we_i  input  1  1 = store, 0 = load.
- core_size_i  input  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
- core_addr_i  input  32  byte address from the ALU.
- core_wd_i  input  32  store data (rs2).
- core_rd_o  output  32  extended load data; valid in the RESP cycle of a load.
- core_stall_o  output  1  hold PC/register file while 1.
- core_misalign_o  output  1  one-cycle pulse: misaligned or unsupported size; no memory access made.
- core_bus_err_o  output  1  one-cycle pulse: access timed out.
- mem_req_o  output  1  memory request, registered.
- mem_we_o  output  1  memory write enable, registered.
- mem_be_o  output  4  byte enables, registered.
- mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}, registered.
- mem_wd_o  output  32  lane-replicated store data, registered.
- mem_rd_i  input  32  memory read word; sampled when `mem_ready_i`=1.
- mem_ready_i  input  1  memory completes the current request.

Behaviour:
- Reset: state=IDLE, counter=0. All registered outputs go to 0, and `core_rd_o`=0.
- States: IDLE, REQ, RESP.
- IDLE, `core_req_i`=0: `core_stall_o`=0, stay in IDLE.
- IDLE, `core_req_i`=1 and the access is illegal:
  - Illegal means size in {3,6,7}; or H/HU with addr[0]=1; or W with addr[1:0]!=0.
  - `core_misalign_o`=1 (combinational), `core_stall_o`=0.
  - No memory request; stay in IDLE.
- IDLE, `core_req_i`=1 and the access is legal:
  - `core_stall_o`=1 (combinational).
  - Capture `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wd_o`, size and addr[1:0]; set `mem_req_o`=1 next cycle.
  - Go to REQ.
- Byte enables and store data:
  - B/BU: be = 4'b0001 << addr[1:0]; wd = {4{core_wd_i[7:0]}}.
  - H/HU: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{core_wd_i[15:0]}}.
  - W: be = 4'b1111; wd = core_wd_i.
- REQ:
  - `core_stall_o`=1; `mem_req_o` and the other registered outputs are held stable.
  - Counter increments each cycle.
  - On `mem_ready_i`=1: for a load, latch extended data; `mem_req_o`=0 next cycle; counter cleared; go to RESP.
  - Else if counter = TIMEOUT_CYCLES-1: `mem_req_o`=0 next cycle, latched data=0, error flag set, go to RESP.
  - `mem_ready_i` takes priority over timeout in the same cycle.
- RESP:
  - `core_stall_o`=0 and `core_rd_o` = latched data (for stores, `core_rd_o` is don't-care).
  - `core_bus_err_o`=1 if timed out.
  - Always returns to IDLE next cycle; the core advances on this edge.
- Load extension, lane selected by the captured addr[1:0]:
  - B: sign-extend byte.
  - BU: zero-extend byte.
  - H: sign-extend the half selected by addr[1].
  - HU: zero-extend that half.
  - W: word unchanged.
- Latency: a legal access with memory ready in the first REQ cycle stalls 2 cycles (IDLE, REQ); the result appears in RESP.
- `mem_ready_i` outside REQ is ignored.
- `core_req_i` is not sampled in REQ or RESP.
- Reset mid-access: the next state is IDLE and `mem_req_o`=0, regardless of `mem_ready_i`.
- Back-to-back memory instructions: each gets its own IDLE→REQ→RESP sequence; no request is issued twice.

Test Plan:
- Reset with `rst_i`=1 for 2 cycles while `core_req_i`=1 → `mem_req_o`=0, `core_stall_o`=0, and all outputs 0 after release until a request.
- SB with addr=0x1003, wd=0xAABBCCDD, ready in the first REQ cycle → one REQ cycle with be=4'b1000, mem_addr=0x1000, mem_wd=0xDDDDDDDD, we=1; stall for 2 cycles, then 0.
- LB vs LBU at addr=0x2001, mem_rd=0x1234F6FF, ready after 3 cycles → LB gives `core_rd_o`=0xFFFFFFF6 and LBU gives 0x000000F6 in RESP; stall held 4 cycles.
- LW at 0x3002 → `core_misalign_o`=1 for 1 cycle, `mem_req_o` never asserted, stall 0. Same for LH at 0x3001 and for size=3.
- LW with `mem_ready_i` held 0 and TIMEOUT_CYCLES=16 → `mem_req_o` high exactly 16 cycles; then `core_bus_err_o` pulse, `core_rd_o`=0, return to IDLE.
- LH at 0x4002 (mem_rd=0x8001_0000) followed immediately by SW at 0x4004 → first gives rd=0xFFFF8001; second is issued as a new request with be=4'b1111, with no duplicate request.
